forwarding_hazard_unit: RTL and testbench
=========================================

// Module: forwarding_hazard_unit
// PURPOSE
//   Decode-stage hazard and forwarding controller for the 5-stage MIPS pipeline.
//   It tracks destination tags of the instructions in EX and MEM, and drives the
//   4-bit redirection_ctrl consumed by the EX-stage operand redirection muxes.
//   It detects load-use hazards, stalls PC/IF/ID for the required cycles and
//   inserts bubbles into EX. Branch flushes discard the ID instruction.
// PARAMETERS
//   REG_ADDR_W       5   register index width
//   LOAD_USE_STALLS  1   bubble cycles inserted per load-use hazard (1..3)
//   CNT_W            32  width of the stall statistics counter
// PORTS
//   clk            in   1           pipeline clock, rising edge
//   rst            in   1           synchronous reset, active high
//   id_valid       in   1           ID holds a real instruction
//   id_rs          in   REG_ADDR_W  source register A of the ID instruction
//   id_rt          in   REG_ADDR_W  source register B of the ID instruction
//   id_use_rs      in   1           ID instruction reads rs
//   id_use_rt      in   1           ID instruction reads rt
//   id_dest        in   REG_ADDR_W  destination register of the ID instruction
//   id_reg_write   in   1           ID instruction writes the register file
//   id_mem_read    in   1           ID instruction is a load
//   flush          in   1           branch/jump taken in EX; kill the ID instruction
//   stall          out  1           combinational; freeze PC and the IF/ID register
//   redirection_ctrl out 4          registered; valid while the instruction is in EX
//   stall_count    out  CNT_W       saturating count of stall cycles
// BEHAVIOUR
//   - Clock and reset: a single clock. rst is synchronous and active high.
//   - Reset: all tags are invalid, redirection_ctrl=4'b0000, stall_count=0 and the FSM is IDLE.
//     While rst=1, stall is forced to 0.
//   - Tag pipeline: the ex_* tag holds {valid,dest,reg_write,mem_read} and the mem_* tag
//     holds {valid,dest,reg_write}. Both tags update every cycle:
//     mem <= ex; ex <= (stall|flush|!id_valid) ? bubble : ID fields.
//   - Producer match: valid & reg_write & dest!=0 & dest==src & use_src.
//     Register $0 is never forwarded.
//   - redirection_ctrl (next value is computed from the ID inputs and latched at the clock edge):
//     [0]  rs matches the ex tag (the producer's result is alu_out next cycle)
//     [1]  rs matches the mem tag and does not match the ex tag (mem_out next cycle)
//     [2]  rt matches the ex tag
//     [3]  rt matches the mem tag and does not match the ex tag
//     Bits [0] and [1] are never both 1, and bits [2] and [3] are never both 1.
//     The youngest producer wins. Bubble, flush or stall cycles latch 4'b0000.
//   - Load-use hazard: the ex tag has mem_read=1 and matches rs or rt of a valid ID instruction.
//   - FSM IDLE: on a load-use hazard with flush=0, stall=1 combinationally.
//     - LOAD_USE_STALLS=1: stay in IDLE. The next cycle re-evaluates, and the load is
//       now in mem, so the operand is forwarded via bit [1] or [3].
//     - LOAD_USE_STALLS>1: go to STALL, load cnt=LOAD_USE_STALLS-1.
//   - FSM STALL: stall=1 and cnt decrements. At cnt==1, go to IDLE.
//     A producer that has left MEM needs no forwarding; the regfile is write-first.
//   - Flush priority: flush=1 forces stall=0, clears the FSM to IDLE and places a bubble in EX.
//     Flush wins over a hazard detected in the same cycle.
//   - stall_count increments on every cycle with stall=1 and saturates at all-ones.
//   - Reset mid-stall: the FSM returns to IDLE and stall=0 in the same cycle; the count clears.
//   - id_valid=0: no hazard is detected, stall=0, and a bubble enters EX.
// TESTING
//   1. EX->EX forwarding: add $3 in ID, then sub $4,$3,$5 -> in sub's EX cycle
//      redirection_ctrl=4'b0001, stall=0.
//   2. MEM->EX forwarding: add $3; nop; or $6,$7,$3 -> in or's EX cycle redirection_ctrl=4'b1000.
//      Also, add $3; add $3; and $8,$3,$3 -> 4'b0101 (youngest wins).
//   3. Load-use with LOAD_USE_STALLS=1: lw $2; add $9,$2,$2 -> stall=1 for exactly 1 cycle,
//      one bubble with ctrl=0, then add's EX has redirection_ctrl=4'b1010 and stall_count=1.
//   4. $0 and flush: lw $0; add $1,$0,$0 -> stall=0, ctrl=0. lw $2 with flush=1 in the
//      hazard cycle -> stall=0, bubble in EX, stall_count unchanged.
//   5. LOAD_USE_STALLS=3: lw $2; add $5,$2,$0 -> stall held 3 cycles, then ctrl=0.
//      rst=1 asserted on the 2nd stall cycle -> stall=0 the same cycle, ctrl=0 and count=0
//      the next cycle.

Source files
------------

// File: rtl/forwarding_hazard_unit_if.sv
// Decode-stage to hazard-unit bundle: ID instruction fields and flush in,
// stall / operand redirection / statistics out.
interface forwarding_hazard_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_use_rs;
  logic                  id_use_rt;
  logic [REG_ADDR_W-1:0] id_dest;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  flush;
  logic                  stall;
  logic [3:0]            redirection_ctrl;
  logic [CNT_W-1:0]      stall_count;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           id_dest, id_reg_write, id_mem_read, flush,
    input  stall, redirection_ctrl, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           id_dest, id_reg_write, id_mem_read, flush,
    output stall, redirection_ctrl, stall_count
  );
endinterface

// File: rtl/forwarding_hazard_unit.sv
// Hazard/forwarding controller for a 5-stage MIPS pipeline: tracks EX/MEM
// destination tags, drives EX operand redirection and load-use stalls.
module forwarding_hazard_unit #(
  parameter int REG_ADDR_W      = 5,
  parameter int LOAD_USE_STALLS = 1,
  parameter int CNT_W           = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  forwarding_hazard_unit_if.slave bus
);
  localparam int SCNT_W = 2;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] STALL = 1'b1;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dest;
    logic                  reg_write;
    logic                  mem_read;
  } ex_tag_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dest;
    logic                  reg_write;
  } mem_tag_t;

  ex_tag_t           ex_tag, ex_tag_nxt;
  mem_tag_t          mem_tag;
  logic [0:0]        state, state_nxt;
  logic [SCNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]        ctrl, ctrl_nxt;
  logic [CNT_W-1:0]  stall_count;

  logic rs_ex, rs_mem, rt_ex, rt_mem;
  logic load_use, stall_c, bubble;

  // Register $0 is hardwired to zero, so it never has a producer to forward from.
  function automatic logic producer_match(
    input logic                  valid,
    input logic [REG_ADDR_W-1:0] dest,
    input logic                  reg_write,
    input logic [REG_ADDR_W-1:0] src,
    input logic                  use_src
  );
    return valid & reg_write & (dest != '0) & (dest == src) & use_src;
  endfunction

  assign rs_ex  = producer_match(ex_tag.valid, ex_tag.dest, ex_tag.reg_write, bus.id_rs, bus.id_use_rs);
  assign rt_ex  = producer_match(ex_tag.valid, ex_tag.dest, ex_tag.reg_write, bus.id_rt, bus.id_use_rt);
  assign rs_mem = producer_match(mem_tag.valid, mem_tag.dest, mem_tag.reg_write, bus.id_rs, bus.id_use_rs);
  assign rt_mem = producer_match(mem_tag.valid, mem_tag.dest, mem_tag.reg_write, bus.id_rt, bus.id_use_rt);

  assign load_use = bus.id_valid & ex_tag.mem_read & (rs_ex | rt_ex);
  // Flush and reset both dominate any stall request, including one already in progress.
  assign stall_c  = ~rst & ~bus.flush & ((state == STALL) | load_use);
  assign bubble   = stall_c | bus.flush | ~bus.id_valid;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    ex_tag_nxt = '0;
    ctrl_nxt   = 4'b0000;
    if (!bubble) begin
      ex_tag_nxt.valid     = 1'b1;
      ex_tag_nxt.dest      = bus.id_dest;
      ex_tag_nxt.reg_write = bus.id_reg_write;
      ex_tag_nxt.mem_read  = bus.id_mem_read;
      // EX is the younger producer, so it masks a MEM match on the same source.
      ctrl_nxt = {rt_mem & ~rt_ex, rt_ex, rs_mem & ~rs_ex, rs_ex};
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (bus.flush) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (state == IDLE) begin
      if (load_use && (LOAD_USE_STALLS > 1)) begin
        state_nxt = STALL;
        cnt_nxt   = SCNT_W'(LOAD_USE_STALLS - 1);
      end
    end else begin
      cnt_nxt = cnt - SCNT_W'(1);
      if (cnt == SCNT_W'(1)) state_nxt = IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_tag      <= '0;
      mem_tag     <= '0;
      state       <= IDLE;
      cnt         <= '0;
      ctrl        <= 4'b0000;
      stall_count <= '0;
    end else begin
      mem_tag.valid     <= ex_tag.valid;
      mem_tag.dest      <= ex_tag.dest;
      mem_tag.reg_write <= ex_tag.reg_write;
      ex_tag            <= ex_tag_nxt;
      state             <= state_nxt;
      cnt               <= cnt_nxt;
      ctrl              <= ctrl_nxt;
      if (stall_c && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
    end
  end

  assign bus.stall            = stall_c;
  assign bus.redirection_ctrl = ctrl;
  assign bus.stall_count      = stall_count;
endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Bench for forwarding_hazard_unit: three configurations share one ID stream and
// are compared every cycle against an in-flight-instruction model, plus directed checks.
module tb_forwarding_hazard_unit;
  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic [4:0] dest;
    logic       rw;
    logic       mr;
    logic       flush;
  } id_t;

  typedef struct packed {
    logic       v;
    logic [4:0] dest;
    logic       rw;
    logic       mr;
  } ins_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  id_t  cur = '0;
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   started = 0;
  bit   have_nx = 0;

  always #5 clk = ~clk;

  forwarding_hazard_unit_if #(.REG_ADDR_W(5), .CNT_W(32)) bus_a ();
  forwarding_hazard_unit_if #(.REG_ADDR_W(5), .CNT_W(32)) bus_b ();
  forwarding_hazard_unit_if #(.REG_ADDR_W(5), .CNT_W(2))  bus_c ();

  forwarding_hazard_unit #(.REG_ADDR_W(5), .LOAD_USE_STALLS(1), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave));
  forwarding_hazard_unit #(.REG_ADDR_W(5), .LOAD_USE_STALLS(3), .CNT_W(32)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave));
  forwarding_hazard_unit #(.REG_ADDR_W(5), .LOAD_USE_STALLS(2), .CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .bus(bus_c.slave));

  assign bus_a.id_valid = cur.valid;  assign bus_b.id_valid = cur.valid;  assign bus_c.id_valid = cur.valid;
  assign bus_a.id_rs = cur.rs;        assign bus_b.id_rs = cur.rs;        assign bus_c.id_rs = cur.rs;
  assign bus_a.id_rt = cur.rt;        assign bus_b.id_rt = cur.rt;        assign bus_c.id_rt = cur.rt;
  assign bus_a.id_use_rs = cur.use_rs; assign bus_b.id_use_rs = cur.use_rs; assign bus_c.id_use_rs = cur.use_rs;
  assign bus_a.id_use_rt = cur.use_rt; assign bus_b.id_use_rt = cur.use_rt; assign bus_c.id_use_rt = cur.use_rt;
  assign bus_a.id_dest = cur.dest;    assign bus_b.id_dest = cur.dest;    assign bus_c.id_dest = cur.dest;
  assign bus_a.id_reg_write = cur.rw; assign bus_b.id_reg_write = cur.rw; assign bus_c.id_reg_write = cur.rw;
  assign bus_a.id_mem_read = cur.mr;  assign bus_b.id_mem_read = cur.mr;  assign bus_c.id_mem_read = cur.mr;
  assign bus_a.flush = cur.flush;     assign bus_b.flush = cur.flush;     assign bus_c.flush = cur.flush;

  logic        dut_stall [3];
  logic [3:0]  dut_ctrl  [3];
  logic [31:0] dut_cnt   [3];
  assign dut_stall[0] = bus_a.stall;  assign dut_ctrl[0] = bus_a.redirection_ctrl;  assign dut_cnt[0] = bus_a.stall_count;
  assign dut_stall[1] = bus_b.stall;  assign dut_ctrl[1] = bus_b.redirection_ctrl;  assign dut_cnt[1] = bus_b.stall_count;
  assign dut_stall[2] = bus_c.stall;  assign dut_ctrl[2] = bus_c.redirection_ctrl;  assign dut_cnt[2] = 32'(bus_c.stall_count);

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic id_t nop();
    id_t v = '0;
    return v;
  endfunction

  function automatic id_t alu(input int d, input int s, input int t);
    id_t v = '0;
    v.valid = 1'b1; v.rs = 5'(s); v.rt = 5'(t); v.use_rs = 1'b1; v.use_rt = 1'b1;
    v.dest = 5'(d); v.rw = 1'b1;
    return v;
  endfunction

  function automatic id_t lw(input int d);
    id_t v = '0;
    v.valid = 1'b1; v.use_rs = 1'b1; v.dest = 5'(d); v.rw = 1'b1; v.mr = 1'b1;
    return v;
  endfunction

  // Model: per configuration, the two in-flight instructions (0 = EX, 1 = MEM),
  // remaining forced stall cycles, and the registered outputs.
  int          lus [3] = '{1, 3, 2};
  int          cw  [3] = '{32, 32, 2};
  ins_t        pipe [3][2];
  int          left [3];
  logic [3:0]  m_ctrl [3];
  longint      m_cnt [3];
  ins_t        n_pipe [3][2];
  int          n_left [3];
  logic [3:0]  n_ctrl [3];
  longint      n_cnt [3];

  function automatic bit produces(input ins_t p, input logic [4:0] src, input logic use_src);
    return p.v && p.rw && (p.dest != 0) && (p.dest == src) && use_src;
  endfunction

  // Search youngest-first; the first producer found supplies the operand.
  function automatic logic [1:0] source_sel(input ins_t ex, input ins_t mem,
                                            input logic [4:0] src, input logic use_src);
    ins_t inflight [2];
    inflight[0] = ex; inflight[1] = mem;
    for (int i = 0; i < 2; i++)
      if (produces(inflight[i], src, use_src)) return 2'(1 << i);
    return 2'b00;
  endfunction

  initial begin
    for (int k = 0; k < 3; k++) begin
      pipe[k][0] = '0; pipe[k][1] = '0; left[k] = 0; m_ctrl[k] = 4'b0; m_cnt[k] = 0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        bit     haz, st, bub;
        longint mx;
        ins_t   iss;
        mx = (cw[k] >= 32) ? 64'hFFFF_FFFF : ((64'd1 << cw[k]) - 1);
        if (rst) begin
          st = 0;
          n_pipe[k][0] = '0; n_pipe[k][1] = '0; n_left[k] = 0; n_ctrl[k] = 4'b0; n_cnt[k] = 0;
        end else begin
          haz = cur.valid && pipe[k][0].mr &&
                (produces(pipe[k][0], cur.rs, cur.use_rs) || produces(pipe[k][0], cur.rt, cur.use_rt));
          st  = !cur.flush && (left[k] > 0 || haz);
          bub = st || cur.flush || !cur.valid;
          n_ctrl[k] = bub ? 4'b0 : {source_sel(pipe[k][0], pipe[k][1], cur.rt, cur.use_rt),
                                    source_sel(pipe[k][0], pipe[k][1], cur.rs, cur.use_rs)};
          if (cur.flush)       n_left[k] = 0;
          else if (left[k] > 0) n_left[k] = left[k] - 1;
          else if (haz)         n_left[k] = lus[k] - 1;
          else                  n_left[k] = 0;
          n_cnt[k] = (st && m_cnt[k] < mx) ? m_cnt[k] + 1 : m_cnt[k];
          iss.v = 1'b1; iss.dest = cur.dest; iss.rw = cur.rw; iss.mr = cur.mr;
          n_pipe[k][1] = pipe[k][0];
          n_pipe[k][0] = bub ? '0 : iss;
        end
        check($sformatf("stall[%0d]", k), longint'(dut_stall[k]), longint'(st));
        check($sformatf("ctrl[%0d]", k), longint'(dut_ctrl[k]), longint'(m_ctrl[k]));
        check($sformatf("count[%0d]", k), longint'(dut_cnt[k]), m_cnt[k]);
      end
      have_nx = 1;
    end
  end

  always @(posedge clk) begin
    if (have_nx) begin
      for (int k = 0; k < 3; k++) begin
        pipe[k][0] = n_pipe[k][0]; pipe[k][1] = n_pipe[k][1];
        left[k] = n_left[k]; m_ctrl[k] = n_ctrl[k]; m_cnt[k] = n_cnt[k];
      end
    end
  end

  // Present one ID slot for a cycle and return at the middle of that cycle.
  task automatic cyc(input id_t v, input logic r = 1'b0);
    @(posedge clk);
    #1;
    cur = v;
    rst = r;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(nop());
  endtask

  initial begin
    id_t f;
    @(posedge clk);
    started = 1;
    cyc(nop(), 1'b1);
    cyc(nop(), 1'b1);
    cyc(nop());
    check("reset_ctrl", longint'(bus_a.redirection_ctrl), 0);
    check("reset_count", longint'(bus_a.stall_count), 0);
    check("reset_stall", longint'(bus_a.stall), 0);

    // EX->EX
    cyc(alu(3, 1, 2));
    cyc(alu(4, 3, 5));
    check("ex_ex_stall", longint'(bus_a.stall), 0);
    cyc(nop());
    check("ex_ex_ctrl", longint'(bus_a.redirection_ctrl), 4'b0001);
    idle(2);

    // MEM->EX
    cyc(alu(3, 1, 2));
    cyc(nop());
    cyc(alu(6, 7, 3));
    cyc(nop());
    check("mem_ex_ctrl", longint'(bus_a.redirection_ctrl), 4'b1000);
    idle(2);

    // Youngest wins
    cyc(alu(3, 1, 2));
    cyc(alu(3, 1, 2));
    cyc(alu(8, 3, 3));
    cyc(nop());
    check("youngest_ctrl", longint'(bus_a.redirection_ctrl), 4'b0101);
    idle(3);

    // Load-use, one bubble
    cyc(lw(2));
    cyc(alu(9, 2, 2));
    check("lu_stall_1", longint'(bus_a.stall), 1);
    cyc(alu(9, 2, 2));
    check("lu_stall_2", longint'(bus_a.stall), 0);
    check("lu_bubble_ctrl", longint'(bus_a.redirection_ctrl), 0);
    cyc(nop());
    check("lu_fwd_ctrl", longint'(bus_a.redirection_ctrl), 4'b1010);
    check("lu_count", longint'(bus_a.stall_count), 1);
    idle(3);

    // $0 is never a hazard
    cyc(lw(0));
    cyc(alu(1, 0, 0));
    check("r0_stall", longint'(bus_a.stall), 0);
    cyc(nop());
    check("r0_ctrl", longint'(bus_a.redirection_ctrl), 0);
    idle(2);

    // Flush beats hazard
    cyc(lw(2));
    f = alu(9, 2, 2);
    f.flush = 1'b1;
    cyc(f);
    check("flush_stall_a", longint'(bus_a.stall), 0);
    check("flush_stall_b", longint'(bus_b.stall), 0);
    cyc(nop());
    check("flush_ctrl", longint'(bus_a.redirection_ctrl), 0);
    check("flush_count", longint'(bus_a.stall_count), 1);
    idle(3);

    // id_valid=0 detects nothing
    cyc(lw(2));
    f = alu(9, 2, 2);
    f.valid = 1'b0;
    cyc(f);
    check("invalid_stall", longint'(bus_a.stall), 0);
    idle(3);

    // Three-bubble configuration
    cyc(lw(2));
    cyc(alu(5, 2, 0));
    check("lu3_stall_1", longint'(bus_b.stall), 1);
    cyc(alu(5, 2, 0));
    check("lu3_stall_2", longint'(bus_b.stall), 1);
    cyc(alu(5, 2, 0));
    check("lu3_stall_3", longint'(bus_b.stall), 1);
    cyc(alu(5, 2, 0));
    check("lu3_release", longint'(bus_b.stall), 0);
    cyc(nop());
    check("lu3_ctrl", longint'(bus_b.redirection_ctrl), 0);
    check("lu3_count", longint'(bus_b.stall_count), 6);
    idle(3);

    // Reset in the middle of a stall
    cyc(lw(2));
    cyc(alu(5, 2, 0));
    check("rst_pre_stall", longint'(bus_b.stall), 1);
    cyc(alu(5, 2, 0), 1'b1);
    check("rst_stall", longint'(bus_b.stall), 0);
    cyc(nop());
    check("rst_ctrl", longint'(bus_b.redirection_ctrl), 0);
    check("rst_count", longint'(bus_b.stall_count), 0);
    idle(2);

    // Saturation of the narrow counter
    for (int i = 0; i < 2; i++) begin
      cyc(lw(2));
      cyc(alu(9, 2, 2));
      cyc(alu(9, 2, 2));
      idle(3);
    end
    check("sat_count_c", longint'(bus_c.stall_count), 3);
    check("sat_count_a", longint'(bus_a.stall_count), 2);
    check("sat_count_b", longint'(bus_b.stall_count), 6);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
